l1_mem_port_arbiter: RTL and testbench
======================================

// Module: l1_mem_port_arbiter
// PURPOSE
//   Shares one simple memory port between two L1 cache clients (c0 = data cache, c1 = second cache/refresh engine).
//   Sits between the caches' mem_req_*/mem_resp_* ports and the single memory model/bus.
//   Allows one outstanding transaction at a time; requests are latched, responses are routed back to the owner.
// PARAMETERS
//   ADDR_W      32  address width of client and memory ports
//   DATA_W      32  data width of client and memory ports
//   FIXED_PRIO  0   0 = round-robin between clients; 1 = c0 always wins a simultaneous request
// PORTS
//   clk             in   1       clock, all state on rising edge
//   rst_n           in   1       asynchronous, active-low reset
//   cN_req_valid    in   1       client N (N=0,1) request; held with stable fields until cN_resp_valid
//   cN_req_we       in   1       client N write (1) / read (0)
//   cN_req_addr     in   ADDR_W  client N address
//   cN_req_wdata    in   DATA_W  client N write data
//   cN_resp_valid   out  1       one-cycle pulse: client N transaction complete
//   cN_resp_rdata   out  DATA_W  read data for client N, valid with cN_resp_valid
//   mem_req_valid   out  1       request to memory, held until mem_resp_valid
//   mem_req_we      out  1       latched we of granted client
//   mem_req_addr    out  ADDR_W  latched address of granted client
//   mem_req_wdata   out  DATA_W  latched write data of granted client
//   mem_resp_valid  in   1       memory completion pulse
//   mem_resp_rdata  in   DATA_W  memory read data
//   busy            out  1       1 in BUSY or RESP
//   owner           out  1       id of current/last granted client
// BEHAVIOUR
//   FSM states: IDLE, BUSY, RESP.
//   IDLE: if any cNreq_valid, select winner, latch its we/addr/wdata, owner<=winner, -> BUSY. Else stay.
//   Arbitration (FIXED_PRIO=0): single requester wins; both -> client != last_owner; last_owner<=winner.
//   Arbitration (FIXED_PRIO=1): c0 wins on simultaneous request; c1 may starve (documented, accepted).
//   BUSY: mem_req_valid=1 with latched fields; fields never change while BUSY.
//   BUSY & mem_resp_valid: capture mem_resp_rdata into rdata_q, -> RESP.
//   RESP: owner's cN_resp_valid=1 for exactly one cycle, cN_resp_rdata=rdata_q; other client's resp_valid=0; -> IDLE.
//   Latency: req seen in IDLE at cycle t -> mem_req_valid at t+1; mem_resp_valid at cycle m -> cN_resp_valid at m+1.
//   Client contract: deassert or change request the cycle after cN_resp_valid; arbiter re-samples at IDLE (m+2).
//   Min back-to-back turnaround: 1 IDLE cycle between transactions; mem_req_valid low in IDLE and RESP.
//   mem_resp_valid in IDLE or RESP: ignored, no state change, no client pulse.
//   Non-owner request during BUSY/RESP: held off, no effect, served at next IDLE per arbitration.
//   cN_resp_rdata driven to rdata_q for both clients; only resp_valid qualifies it.
//   Reset (any time, incl. mid-transaction): state=IDLE, mem_req_valid=0, mem_req_we=0, mem_req_addr=0,
//     mem_req_wdata=0, cN_resp_valid=0, cN_resp_rdata=0, busy=0, owner=0, last_owner=1 (c0 wins first tie).
//     A memory response arriving after reset release for a pre-reset request is ignored (IDLE rule).
// CONFIGURATION
//   MEM_ARB_STATS_EN defined: adds outputs c0_grants, c1_grants, contention_cycles (32 bit each, reset 0, wrap).
//     cN_grants +1 on each IDLE->BUSY grant to cN; contention_cycles +1 every cycle where a client holds
//     req_valid but is not being served (non-owner in BUSY/RESP, or loser in IDLE).
//   MEM_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
//   Single c0 read addr=0x100, mem responds 3 cycles later with 0xDEADBEEF -> mem_req_valid t+1..t+4,
//     c0_resp_valid one cycle at t+5 with rdata 0xDEADBEEF, c1_resp_valid never asserted.
//   c1 write addr=0x200 wdata=0x12345678 -> mem_req_we=1, addr/wdata stable whole BUSY, c1_resp_valid one pulse.
//   Both request continuously, FIXED_PRIO=0, 6 transactions -> owners c0,c1,c0,c1,c0,c1; grants 3/3 (STATS_EN).
//   Same with FIXED_PRIO=1 -> all 6 grants to c0, c1 never granted while c0 requests.
//   Assert rst_n low while BUSY, then send mem_resp_valid after release -> no resp pulse, state IDLE, mem_req_valid=0.
//   Spurious mem_resp_valid in IDLE -> no cN_resp_valid, busy stays 0, counters unchanged.

Source files
------------

// File: rtl/l1_mem_port_arbiter.sv
// Two-client arbiter for a single memory port: one outstanding transaction, response routed to the owner.
// Optional statistics counters are compiled in when MEM_ARB_STATS_EN is defined.
module l1_mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req_valid,
  input  logic              c0_req_we,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_wdata,
  output logic              c0_resp_valid,
  output logic [DATA_W-1:0] c0_resp_rdata,
  input  logic              c1_req_valid,
  input  logic              c1_req_we,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_wdata,
  output logic              c1_resp_valid,
  output logic [DATA_W-1:0] c1_resp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              busy,
  output logic              owner
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       c0_grants,
  output logic [31:0]       c1_grants,
  output logic [31:0]       contention_cycles
`endif
);

  // Handshake: a client holds req_valid with stable fields until its one-cycle
  // resp_valid; memory sees mem_req_valid held until a one-cycle mem_resp_valid.
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                c0_resp_valid_q, c0_resp_valid_d;
  logic                c1_resp_valid_q, c1_resp_valid_d;
  logic                winner;

  always_comb begin
    winner = 1'b0;
    if (c0_req_valid && c1_req_valid) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_q;
    end else begin
      winner = c1_req_valid;
    end
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    mem_req_valid_d = 1'b0;
    c0_resp_valid_d = 1'b0;
    c1_resp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c0_req_valid || c1_req_valid) begin
          state_d         = ST_BUSY;
          owner_d         = winner;
          last_owner_d    = winner;
          we_d            = winner ? c1_req_we    : c0_req_we;
          addr_d          = winner ? c1_req_addr  : c0_req_addr;
          wdata_d         = winner ? c1_req_wdata : c0_req_wdata;
          mem_req_valid_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_resp_valid) begin
          state_d         = ST_RESP;
          rdata_d         = mem_resp_rdata;
          c0_resp_valid_d = ~owner_q;
          c1_resp_valid_d = owner_q;
        end else begin
          mem_req_valid_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      owner_q         <= 1'b0;
      last_owner_q    <= 1'b1;
      mem_req_valid_q <= 1'b0;
      c0_resp_valid_q <= 1'b0;
      c1_resp_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      owner_q         <= owner_d;
      last_owner_q    <= last_owner_d;
      mem_req_valid_q <= mem_req_valid_d;
      c0_resp_valid_q <= c0_resp_valid_d;
      c1_resp_valid_q <= c1_resp_valid_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign c0_resp_valid = c0_resp_valid_q;
  assign c1_resp_valid = c1_resp_valid_q;
  assign c0_resp_rdata = rdata_q;
  assign c1_resp_rdata = rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign owner         = owner_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] c0_grants_q, c0_grants_d;
  logic [31:0] c1_grants_q, c1_grants_d;
  logic [31:0] contention_q, contention_d;
  logic        unserved;

  // At most one client can be waiting in any cycle, so contention steps by one.
  always_comb begin
    unserved = 1'b0;
    if (state_q == ST_IDLE) begin
      unserved = c0_req_valid && c1_req_valid;
    end else begin
      unserved = owner_q ? c0_req_valid : c1_req_valid;
    end
    c0_grants_d  = c0_grants_q;
    c1_grants_d  = c1_grants_q;
    contention_d = contention_q + {31'd0, unserved};
    if ((state_q == ST_IDLE) && (c0_req_valid || c1_req_valid)) begin
      if (winner) c1_grants_d = c1_grants_q + 32'd1;
      else        c0_grants_d = c0_grants_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_grants_q  <= '0;
      c1_grants_q  <= '0;
      contention_q <= '0;
    end else begin
      c0_grants_q  <= c0_grants_d;
      c1_grants_q  <= c1_grants_d;
      contention_q <= contention_d;
    end
  end

  assign c0_grants         = c0_grants_q;
  assign c1_grants         = c1_grants_q;
  assign contention_cycles = contention_q;
`endif

endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
// Bench for l1_mem_port_arbiter: round-robin instance plus a FIXED_PRIO=1 instance, scoreboarded responses.
// Statistics checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_l1_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          c0_req_valid = 0, c0_req_we = 0, c1_req_valid = 0, c1_req_we = 0;
  logic [AW-1:0] c0_req_addr = '0, c1_req_addr = '0;
  logic [DW-1:0] c0_req_wdata = '0, c1_req_wdata = '0;
  logic          c0_resp_valid, c1_resp_valid, mem_req_valid, mem_req_we, busy, owner;
  logic [DW-1:0] c0_resp_rdata, c1_resp_rdata, mem_req_wdata;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid = 0;
  logic [DW-1:0] mem_resp_rdata = '0;

  logic          f_c0_req_valid = 0, f_c1_req_valid = 0;
  logic          f_c0_resp_valid, f_c1_resp_valid, f_mem_req_valid, f_mem_req_we, f_busy, f_owner;
  logic [DW-1:0] f_c0_resp_rdata, f_c1_resp_rdata, f_mem_req_wdata;
  logic [AW-1:0] f_mem_req_addr;
  logic          f_mem_resp_valid = 0;
  logic [DW-1:0] f_mem_resp_rdata = '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] c0_grants, c1_grants, contention_cycles;
  logic [31:0] f_c0_grants, f_c1_grants, f_contention_cycles;
`endif

  l1_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req_valid(c0_req_valid), .c0_req_we(c0_req_we), .c0_req_addr(c0_req_addr),
    .c0_req_wdata(c0_req_wdata), .c0_resp_valid(c0_resp_valid), .c0_resp_rdata(c0_resp_rdata),
    .c1_req_valid(c1_req_valid), .c1_req_we(c1_req_we), .c1_req_addr(c1_req_addr),
    .c1_req_wdata(c1_req_wdata), .c1_resp_valid(c1_resp_valid), .c1_resp_rdata(c1_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .owner(owner)
`ifdef MEM_ARB_STATS_EN
    , .c0_grants(c0_grants), .c1_grants(c1_grants), .contention_cycles(contention_cycles)
`endif
  );

  l1_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .c0_req_valid(f_c0_req_valid), .c0_req_we(c0_req_we), .c0_req_addr(c0_req_addr),
    .c0_req_wdata(c0_req_wdata), .c0_resp_valid(f_c0_resp_valid), .c0_resp_rdata(f_c0_resp_rdata),
    .c1_req_valid(f_c1_req_valid), .c1_req_we(c1_req_we), .c1_req_addr(c1_req_addr),
    .c1_req_wdata(c1_req_wdata), .c1_resp_valid(f_c1_resp_valid), .c1_resp_rdata(f_c1_resp_rdata),
    .mem_req_valid(f_mem_req_valid), .mem_req_we(f_mem_req_we), .mem_req_addr(f_mem_req_addr),
    .mem_req_wdata(f_mem_req_wdata), .mem_resp_valid(f_mem_resp_valid), .mem_resp_rdata(f_mem_resp_rdata),
    .busy(f_busy), .owner(f_owner)
`ifdef MEM_ARB_STATS_EN
    , .c0_grants(f_c0_grants), .c1_grants(f_c1_grants), .contention_cycles(f_contention_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_fp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory models: respond mem_lat cycles after the first BUSY cycle with ~addr.
  bit auto_mem = 0;
  int mem_lat  = 1;
  int mcnt     = 0;
  int fcnt     = 0;
  always @(negedge clk) begin
    if (auto_mem) begin
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        if (mcnt == mem_lat) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = ~mem_req_addr;
          mcnt = 0;
        end else mcnt++;
      end
    end
  end
  always @(negedge clk) begin
    f_mem_resp_valid = 1'b0;
    if (f_mem_req_valid) begin
      if (fcnt == 1) begin
        f_mem_resp_valid = 1'b1;
        f_mem_resp_rdata = ~f_mem_req_addr;
        fcnt = 0;
      end else fcnt++;
    end
  end

  // Scoreboard monitors: {client id, rdata} popped on every response pulse.
  always @(negedge clk) begin
    if (c0_resp_valid && c1_resp_valid) check("rr_both_resp", 1, 0);
    else if (c0_resp_valid || c1_resp_valid) begin
      if (exp_q.size() == 0) check("rr_unexpected_resp", {31'd0, c1_resp_valid, c0_resp_rdata}, 0);
      else check("rr_resp", {c1_resp_valid, c1_resp_valid ? c1_resp_rdata : c0_resp_rdata},
                 exp_q.pop_front());
    end
  end
  always @(negedge clk) begin
    if (f_c0_resp_valid && f_c1_resp_valid) check("fp_both_resp", 1, 0);
    else if (f_c0_resp_valid || f_c1_resp_valid) begin
      if (exp_fp_q.size() == 0) check("fp_unexpected_resp", {31'd0, f_c1_resp_valid, f_c0_resp_rdata}, 0);
      else check("fp_resp", {f_c1_resp_valid, f_c1_resp_valid ? f_c1_resp_rdata : f_c0_resp_rdata},
                 exp_fp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] s0, s1, sc;
`endif
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_addr", mem_req_addr, 0);
    check("rst_resp", {c0_resp_valid, c1_resp_valid, c0_resp_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single c0 read, memory answers on the 4th BUSY cycle
    c0_req_valid = 1; c0_req_we = 0; c0_req_addr = 32'h100;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    check("t1_idle_no_req", mem_req_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("t1_busy_req", {mem_req_valid, mem_req_we, busy, owner, c0_resp_valid}, 5'b10100);
      check("t1_busy_addr", mem_req_addr, 32'h100);
      if (i == 4) begin mem_resp_valid = 1; mem_resp_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk);
    mem_resp_valid = 0;
    check("t1_resp_cycle", {c0_resp_valid, c1_resp_valid, mem_req_valid, busy}, 4'b1001);
    c0_req_valid = 0;
    @(negedge clk);
    check("t1_back_idle", {c0_resp_valid, busy}, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // c1 write, fields held stable across BUSY
    auto_mem = 1; mem_lat = 2;
    c1_req_valid = 1; c1_req_we = 1; c1_req_addr = 32'h200; c1_req_wdata = 32'h12345678;
    exp_q.push_back({1'b1, 32'hFFFFFDFF});
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (c1_resp_valid) begin
        check("t2_resp_req_low", mem_req_valid, 0);
        c1_req_valid = 0;
        done = 1;
      end else begin
        check("t2_busy_fields", {mem_req_valid, mem_req_we, owner}, 3'b111);
        check("t2_busy_addr", mem_req_addr, 32'h200);
        check("t2_busy_wdata", mem_req_wdata, 32'h12345678);
      end
    end
    if (!done) check("t2_resp_timeout", 0, 1);
    @(negedge clk);
    check("t2_single_pulse", {c1_resp_valid, busy}, 0);

    // Reset while BUSY; a late memory response is ignored
    auto_mem = 0;
    c0_req_valid = 1; c0_req_addr = 32'h500; c0_req_we = 0;
    repeat (2) @(negedge clk);
    check("t4_busy_before_rst", busy, 1);
    rst_n = 0; c0_req_valid = 0;
    #1;
    check("t4_rst_outputs", {mem_req_valid, mem_req_we, busy, owner, c0_resp_valid, c1_resp_valid}, 0);
    check("t4_rst_fields", {mem_req_addr, mem_req_wdata}, 0);
`ifdef MEM_ARB_STATS_EN
    check("t4_rst_stats", {c0_grants, c1_grants} | {32'd0, contention_cycles}, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_resp_valid = 0;
    check("t4_late_resp", {mem_req_valid, busy, c0_resp_valid, c1_resp_valid}, 0);
    @(negedge clk);
    check("t4_late_resp2", {mem_req_valid, busy, c0_resp_valid, c1_resp_valid}, 0);

    // Spurious memory response in IDLE
`ifdef MEM_ARB_STATS_EN
    s0 = c0_grants; s1 = c1_grants; sc = contention_cycles;
`endif
    mem_resp_valid = 1; mem_resp_rdata = 32'h55;
    @(negedge clk);
    mem_resp_valid = 0;
    check("t5_spurious", {busy, c0_resp_valid, c1_resp_valid, mem_req_valid}, 0);
    @(negedge clk);
    check("t5_spurious2", {busy, c0_resp_valid, c1_resp_valid}, 0);
`ifdef MEM_ARB_STATS_EN
    check("t5_stats_same", {c0_grants, c1_grants}, {s0, s1});
    check("t5_contention_same", contention_cycles, sc);
`endif

    // Round-robin with both clients requesting continuously (c0 wins first tie after reset)
    auto_mem = 1; mem_lat = 1;
    c0_req_we = 0; c1_req_we = 0; c0_req_addr = 32'h300; c1_req_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 32'hFFFFFCFF});
      exp_q.push_back({1'b1, 32'hFFFFFBFF});
    end
    c0_req_valid = 1; c1_req_valid = 1;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (c0_resp_valid || c1_resp_valid) n++;
      if (n == 6) begin c0_req_valid = 0; c1_req_valid = 0; end
    end
    check("t3_resp_count", n, 6);
    @(negedge clk);
    check("t3_sb_empty", exp_q.size(), 0);
`ifdef MEM_ARB_STATS_EN
    check("t3_grants", {c0_grants, c1_grants}, {32'd3, 32'd3});
    check("t3_contention", contention_cycles, 32'd23);
`endif

    // Fixed priority: c0 takes every grant while it keeps requesting
    for (int i = 0; i < 6; i++) exp_fp_q.push_back({1'b0, 32'hFFFFFCFF});
    f_c0_req_valid = 1; f_c1_req_valid = 1;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (f_busy) check("t6_fp_owner", f_owner, 0);
      if (f_c0_resp_valid || f_c1_resp_valid) n++;
      if (n == 6) begin f_c0_req_valid = 0; f_c1_req_valid = 0; end
    end
    check("t6_resp_count", n, 6);
    @(negedge clk);
    check("t6_sb_empty", exp_fp_q.size(), 0);
`ifdef MEM_ARB_STATS_EN
    check("t6_grants", {f_c0_grants, f_c1_grants}, {32'd6, 32'd0});
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
